// File: rtl/song_pkg.sv
// song_pkg: ROM entry field positions, voice count and FSM states shared by the song sequencer.
package song_pkg;
  localparam int ADV_BIT  = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;
  localparam int META_MSB = 2;
  localparam int META_LSB = 0;
  localparam logic [5:0] NOTE_REST = 6'd0;
  localparam int NUM_VOICES = 3;
  typedef enum logic [2:0] {IDLE, ADDR, DECODE, WAIT, NEXT, DONE} state_t;
  function automatic logic [1:0] next_voice(input logic [1:0] v);
    return v == 2'(NUM_VOICES - 1) ? 2'd0 : v + 2'd1;
  endfunction
endpackage

// File: rtl/beat_timer.sv
// beat_timer: beat-count hold timer; expire flags the qualifying beat that takes it from 1 to 0.
module beat_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [5:0] dur,
  input  logic       beat,
  input  logic       en,
  output logic       expire
);
  logic [5:0] cnt;
  assign expire = en && beat && cnt == 6'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= dur;
    else if (en && beat && cnt != '0) cnt <= cnt - 6'd1;
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: fetches song ROM entries, dispatches notes round-robin to three voices, holds on advance entries.
module song_sequencer
  import song_pkg::*;
#(
  parameter int SONG_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 play,
  input  logic [SONG_BITS-1:0] song_sel,
  input  logic                 beat,
  input  logic [15:0]          rom_dout,
  output logic [6:0]           rom_addr,
  output logic [5:0]           note_out,
  output logic [5:0]           dur_out,
  output logic [2:0]           meta_out,
  output logic [2:0]           note_load,
  output logic                 busy,
  output logic                 song_done
);
  localparam int EW = 7 - SONG_BITS;
  state_t state, nxt;
  logic [SONG_BITS-1:0] song_q;
  logic [EW-1:0] entry;
  logic [1:0] vp;
  logic [5:0] note_q, dur_q, rnote, rdur;
  logic [2:0] meta_q, rmeta;
  logic chg, start, ld, adv_wait, expire;
  always_comb begin
    rnote = rom_dout[NOTE_MSB:NOTE_LSB];
    rdur = rom_dout[DUR_MSB:DUR_LSB];
    rmeta = rom_dout[META_MSB:META_LSB];
    chg = state inside {ADDR, DECODE, WAIT, NEXT} && play && song_sel != song_q;
    start = chg || (state == IDLE && play);
    ld = state == DECODE && rnote != NOTE_REST;
    adv_wait = state == DECODE && rom_dout[ADV_BIT] && rdur != '0;
    nxt = state;
    if (chg) nxt = ADDR;
    else
      case (state)
        IDLE:    nxt = play ? ADDR : IDLE;
        ADDR:    nxt = play ? DECODE : ADDR;
        DECODE:  nxt = adv_wait ? WAIT : NEXT;
        WAIT:    nxt = expire ? NEXT : WAIT;
        NEXT:    nxt = !play ? NEXT : &entry ? DONE : ADDR;
        DONE:    nxt = play ? DONE : IDLE;
        default: nxt = IDLE;
      endcase
  end
  // Load fields come straight off the registered ROM data in DECODE; the hold registers keep them afterwards.
  assign note_load = ld ? 3'b001 << vp : 3'b000;
  assign note_out = ld ? rnote : note_q;
  assign dur_out = ld ? rdur : dur_q;
  assign meta_out = ld ? rmeta : meta_q;
  assign busy = state != IDLE;
  beat_timer u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .load(adv_wait && !chg),
    .dur(rdur),
    .beat(beat),
    .en(state == WAIT && play),
    .expire(expire)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      song_q <= '0;
      entry <= '0;
      vp <= '0;
      rom_addr <= '0;
      note_q <= '0;
      dur_q <= '0;
      meta_q <= '0;
      song_done <= 1'b0;
    end else begin
      state <= nxt;
      song_done <= state == NEXT && nxt == DONE;
      if (ld) begin
        note_q <= rnote;
        dur_q <= rdur;
        meta_q <= rmeta;
      end
      if (start) begin
        song_q <= song_sel;
        entry <= '0;
        vp <= '0;
        rom_addr <= {song_sel, EW'(0)};
      end else begin
        if (ld) vp <= next_voice(vp);
        if (state == NEXT && nxt == ADDR) begin
          entry <= entry + EW'(1);
          rom_addr <= {song_q, entry + EW'(1)};
        end
      end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed plus randomized song playback checked against a load-list reference model.
module tb_song_sequencer;
  logic clk = 0, reset_n = 0, play = 0, beat = 0;
  logic [1:0] song_sel = 0;
  logic [15:0] rom_dout;
  logic [15:0] rom [128];
  logic [6:0] rom_addr;
  logic [5:0] note_out, dur_out;
  logic [2:0] meta_out, note_load;
  logic busy, song_done;
  int total = 0, passed = 0, done_cnt = 0, max_addr = 0;
  logic [17:0] exp_q[$];
  song_sequencer #(.SONG_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .play(play), .song_sel(song_sel), .beat(beat),
    .rom_dout(rom_dout), .rom_addr(rom_addr), .note_out(note_out), .dur_out(dur_out),
    .meta_out(meta_out), .note_load(note_load), .busy(busy), .song_done(song_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_dout <= rom[rom_addr];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      beat = 1;
      tick();
      beat = 0;
    end
  endtask
  function automatic logic [15:0] w(input int a, input int n, input int d, input int m);
    return {1'(a), 6'(n), 6'(d), 3'(m)};
  endfunction
  function automatic logic [15:0] rnd_word();
    return w($urandom % 2, ($urandom % 4 == 0) ? 0 : $urandom_range(1, 63), $urandom % 4, $urandom % 8);
  endfunction
  // Expected loads of a full song: every non-rest entry in order, voices cycling 0,1,2.
  task automatic build(input int s);
    int v = 0;
    for (int e = 0; e < 32; e++) begin
      logic [15:0] x = rom[s * 32 + e];
      if (x[14:9] != 0) begin
        exp_q.push_back({3'(1 << v), x[14:9], x[8:3], x[2:0]});
        v = (v + 1) % 3;
      end
    end
  endtask
  task automatic run_to_done(input int target);
    for (int c = 0; c < 3000 && done_cnt < target; c++) begin
      beat = 1'($urandom % 2);
      tick();
      if (song_sel == 0 && int'(rom_addr) > max_addr) max_addr = rom_addr;
    end
    beat = 0;
    check("song_done_reached", done_cnt, target);
  endtask
  always @(negedge clk)
    if (reset_n) begin
      if (song_done) done_cnt++;
      if (note_load != 0) begin
        if (exp_q.size() == 0) check("unexpected_load", note_load, 0);
        else check("load", {note_load, note_out, dur_out, meta_out}, exp_q.pop_front());
      end
    end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [2:0] wrap [4];
    wrap = '{3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 128; i++) rom[i] = 16'h0;
    tick();
    tick();
    check("rst_addr", rom_addr, 0);
    check("rst_note", note_out, 0);
    check("rst_dur", dur_out, 0);
    check("rst_meta", meta_out, 0);
    check("rst_load", note_load, 0);
    check("rst_busy", busy, 0);
    check("rst_done", song_done, 0);
    reset_n = 1;
    tick();
    rom[0] = w(0, 49, 12, 7);
    rom[1] = w(1, 1, 12, 7);
    rom[2] = w(1, 0, 12, 7);
    for (int i = 3; i < 7; i++) rom[i] = w(0, 20 + i, i + 1, i);
    rom[7] = w(1, 9, 12, 3);
    for (int i = 8; i < 32; i++) rom[i] = rnd_word();
    build(0);
    play = 1;
    tick();
    check("addr0", rom_addr, 0);
    check("busy_run", busy, 1);
    tick();
    check("load0_strobe", note_load, 3'b001);
    check("load0_note", note_out, 49);
    tick();
    check("strobe_one_cycle", note_load, 0);
    tick();
    check("addr1", rom_addr, 1);
    tick();
    check("load1_strobe", note_load, 3'b010);
    check("load1_note", note_out, 1);
    tick();
    check("note_hold", note_out, 1);
    beats(11);
    check("wait_11_beats", rom_addr, 1);
    beats(1);
    check("addr_1_after_beat", rom_addr, 1);
    tick();
    check("addr2_two_cycles", rom_addr, 2);
    tick();
    check("rest_no_load", note_load, 0);
    beats(12);
    tick();
    check("addr3_after_rest", rom_addr, 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("chord_strobe", note_load, wrap[i]);
      tick();
      tick();
    end
    check("addr7", rom_addr, 7);
    tick();
    tick();
    beats(5);
    play = 0;
    beats(20);
    check("pause_frozen", rom_addr, 7);
    play = 1;
    beats(6);
    check("resume_6_beats", rom_addr, 7);
    beats(1);
    tick();
    check("resume_7th_beat", rom_addr, 8);
    run_to_done(1);
    repeat (5) tick();
    check("done_busy", busy, 1);
    check("done_single_pulse", done_cnt, 1);
    check("done_no_pulse_now", song_done, 0);
    check("addr_max", max_addr, 31);
    play = 0;
    tick();
    check("idle_after_release", busy, 0);
    check("song0_loads_all", exp_q.size(), 0);
    rom[0] = w(1, 10, 12, 0);
    for (int i = 64; i < 96; i++) rom[i] = rnd_word();
    exp_q.push_back({3'b001, 6'd10, 6'd12, 3'd0});
    build(2);
    play = 1;
    tick();
    tick();
    tick();
    beats(3);
    song_sel = 2;
    tick();
    check("song_change_addr", rom_addr, 64);
    run_to_done(2);
    check("song2_loads_all", exp_q.size(), 0);
    play = 0;
    tick();
    rom[32] = w(0, 33, 4, 5);
    song_sel = 1;
    play = 1;
    tick();
    tick();
    check("pre_reset_strobe", note_load, 3'b001);
    #1 reset_n = 0;
    #1;
    check("areset_load", note_load, 0);
    check("areset_note", note_out, 0);
    check("areset_dur", dur_out, 0);
    check("areset_meta", meta_out, 0);
    check("areset_addr", rom_addr, 0);
    check("areset_busy", busy, 0);
    check("areset_done", song_done, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
